// File: rtl/tt_uart_pkg.sv
// Shared definitions for the UART transmit stage: FSM encoding and frame constants.
// A frame is one start bit, eight data bits and one stop bit.
package tt_uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int DEFAULT_CLKS_PER_BIT = 87;
   localparam int FRAME_BITS           = 10;
   localparam int FIFO_CNT_W           = 5;

endpackage

// File: rtl/tt_sync_fifo.sv
// Small synchronous FIFO with a combinational head output and an occupancy count.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module tt_sync_fifo #(
   parameter int DEPTH   = 4,
   parameter int WIDTH   = 8,
   parameter int COUNT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic [WIDTH-1:0]   push_data,
   input  logic               pop,
   output logic [WIDTH-1:0]   pop_data,
   output logic               full,
   output logic               empty,
   output logic [COUNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == COUNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/tt_uart_tx_stage.sv
// Buffers result bytes from the core and serialises them as 8N1 UART on tx.
// ena low freezes every register so the block resumes exactly where it stopped.
module tt_uart_tx_stage
   import tt_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4,
   parameter int CNT_W        = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  tx,
   output logic                  busy,
   output logic [FIFO_CNT_W-1:0] fifo_count,
   output logic                  overflow
);

   tx_state_t        state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;
   logic [7:0]       head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   logic             bit_done;

   // Readiness comes from the registered count only, so a full FIFO refuses
   // a push even on the edge where the FSM pops.
   assign in_ready = ena & ~rst & ~fifo_full;
   assign push     = in_valid & in_ready;
   assign pop      = ena & (state == IDLE) & ~fifo_empty;
   assign bit_done = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign busy     = (state != IDLE) | ~fifo_empty;

   tt_sync_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .WIDTH   (8),
      .COUNT_W (FIFO_CNT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (in_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // tx is always loaded one edge ahead so the pin comes straight from a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         tx        <= 1'b1;
         overflow  <= 1'b0;
      end else if (ena) begin
         if (in_valid && !in_ready) begin
            overflow <= 1'b1;
         end
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_idx  <= '0;
               tx       <= 1'b1;
               if (!fifo_empty) begin
                  shift_reg <= head;
                  tx        <= 1'b0;
                  state     <= START;
               end
            end
            START: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  tx       <= shift_reg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'(FRAME_BITS - 3)) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx   <= bit_idx + 1'b1;
                     shift_reg <= {1'b0, shift_reg[7:1]};
                     tx        <= shift_reg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/tt_uart_tx_stage.md
Name: tt_uart_tx_stage

Overview:
Downstream stage of the project core. Accepts result bytes from the core over a valid/ready handshake and buffers them in a small FIFO. Serialises each byte as 8N1 UART on one dedicated output pin (uo_out[0] at top level), so results can be read off the Tiny Tapeout board with a USB-serial adapter.

Parameters:
CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200); legal range 2..4095
FIFO_DEPTH, 4, byte FIFO entries; must be a power of two, 2..16
CNT_W, 12, width of the baud counter; must satisfy 2^CNT_W > CLKS_PER_BIT

Ports:
clk  input  1  design clock, same as top-level clk
rst  input  1  synchronous, active-high reset; top level drives it as ~rst_n
ena  input  1  tile enable; low freezes the block
in_data  input  8  byte from the core
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  FIFO can accept a byte this cycle
tx  output  1  UART line; idle high
busy  output  1  a frame is in progress or the FIFO is non-empty
fifo_count  output  5  current FIFO occupancy, 0..FIFO_DEPTH
overflow  output  1  sticky flag: in_valid was asserted while in_ready was 0

Behaviour:
- Reset values while rst=1, sampled at the clk edge: tx=1, busy=0, in_ready=0, fifo_count=0, overflow=0, FSM=IDLE, baud counter=0, FIFO pointers=0.
- First cycle after reset: in_ready=1.
- Reset asserted mid-frame: tx=1 from the next edge; the partial frame and all FIFO contents are discarded.
- Push: a byte is written on an edge where in_valid & in_ready & ena.
- in_ready = ena & (fifo_count != FIFO_DEPTH). It is registered-count based and does not depend on a pop in the same cycle. A full FIFO therefore refuses a push even when a pop happens in that cycle.
- Pop: the FSM reads the head byte when it is in IDLE, the FIFO is non-empty, and ena=1. The pop and the IDLE->START transition happen on the same edge.
- Simultaneous push and pop: fifo_count is unchanged; data order is preserved.
- Pointers wrap modulo FIFO_DEPTH.
- overflow sets on any edge with in_valid & ~in_ready & ena & ~rst, then holds until reset. The refused byte is dropped.
- FSM states and outputs:
  - IDLE: tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit index counts 0..7.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then back to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1. At terminal count it resets to 0 and the bit or state advances.
- Latency: if a byte is pushed at edge k into an empty FIFO with the FSM idle, it is popped at edge k+1 and tx goes low after edge k+1. Total frame length is 10*CLKS_PER_BIT cycles.
- Back-to-back: if the FIFO is non-empty at the end of STOP, STOP goes to IDLE for exactly one cycle and the next start bit follows immediately. Inter-frame gap is therefore CLKS_PER_BIT+1 cycles of tx=1.
- tx is driven directly from a flop, with no combinational glitch path.
- busy = (state != IDLE) | (fifo_count != 0).
- ena=0: baud counter, FSM, FIFO and overflow all hold; tx holds its current value; no push and no pop occur. When ena returns high, the block resumes exactly where it stopped.

Decomposition:
- Shared package (tt_uart_pkg): FSM state encoding (IDLE, START, DATA, STOP as 2-bit localparams), the default CLKS_PER_BIT, and the frame-length constant (10).
- Sub-module tt_sync_fifo: parameterised depth and width, push/pop/full/empty/count, synchronous active-high rst, no internal enable gating. The parent gates push and pop with ena.
- tt_uart_tx_stage: contains the FSM, baud counter, shift register and overflow flag.

Test Plan (sim uses CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset then idle: hold rst for 3 cycles, then release -> tx=1, busy=0, fifo_count=0, in_ready=1, overflow=0.
- Single byte 0xA5: push at edge k -> tx low on cycles k+1..k+4, then data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high. Total 40 cycles; busy falls after stop.
- Burst of 6 bytes, 0x01..0x06, with in_valid held high:
  - 5 accepted: one is popped at once and 4 are queued.
  - 6th byte is refused: in_ready=0 and overflow=1.
  - tx decodes to 01 02 03 04 05 with 5-cycle gaps.
- Simultaneous push/pop: FIFO holds 1 byte; push 0x3C on the same edge as the pop -> fifo_count stays 1; 0x3C is sent next.
- ena=0 for 7 cycles mid-DATA -> tx frozen at its current bit; the bit completes after ena returns, and the frame is stretched by exactly 7 cycles.
- Reset mid-frame while sending 0xFF with 2 bytes queued -> tx=1 the cycle after; fifo_count=0; nothing further is transmitted.
